// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning slice.
//   db_state_t        : per-channel debounce FSM state (2-bit encoding)
//   EVT_ID_W          : width of the event index presented to the consumer
//   DEBOUNCE_CYC_DEF  : default stable-cycle count (10 ms at 100 MHz)
//   lowest_set()      : fixed-priority encoder, bit 0 has highest priority
package btn_pkg;

  localparam int unsigned EVT_ID_W         = 2;
  localparam int unsigned DEBOUNCE_CYC_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_P   = 2'd1,
    PRESSED = 2'd2,
    ARM_R   = 2'd3
  } db_state_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [EVT_ID_W-1:0] lowest_set(input logic [3:0] mask);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i] && !found) begin
        lowest_set = EVT_ID_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter-based debounce FSM,
// registered clean level and a one-cycle press pulse.
//   clk   : system clock
//   rst   : asynchronous, active-high reset
//   raw   : raw button input, asynchronous to clk, active-high
//   level : debounced level (1 in PRESSED / ARM_R)
//   press : one-cycle pulse on the ARM_P -> PRESSED transition
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             s;
  db_state_t        state;
  db_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic             arm_entry;
  logic             in_arm;

  assign s = sync_q[1];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (s) state_n = ARM_P;
      ARM_P:   if (!s) state_n = IDLE;
               else if (cnt == CNT_LAST) state_n = PRESSED;
      PRESSED: if (!s) state_n = ARM_R;
      ARM_R:   if (s) state_n = PRESSED;
               else if (cnt == CNT_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_arm    = (state == ARM_P) || (state == ARM_R);
  assign arm_entry = ((state_n == ARM_P) || (state_n == ARM_R)) && (state_n != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      state  <= IDLE;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_n;
      if (arm_entry)
        cnt <= '0;
      else if (in_arm)
        cnt <= cnt + CNT_W'(1);
      // Outputs are registered from the next state so they change on the
      // same edge that the FSM enters PRESSED / IDLE.
      level <= (state_n == PRESSED) || (state_n == ARM_R);
      press <= (state == ARM_P) && (state_n == PRESSED);
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions raw push-buttons and queues press events for the consumer.
//   clk          : system clock (100 MHz)
//   rst          : asynchronous, active-high reset
//   btn_raw      : raw button inputs, async to clk, active-high
//   btn_level    : debounced levels
//   btn_press    : one-cycle pulse per accepted press
//   evt_valid    : a press event is pending
//   evt_id       : index of the presented event (lowest pending wins)
//   evt_ready    : consumer accepts when evt_valid & evt_ready at clk rise
//   evt_overflow : sticky, a press was lost because it was already pending
//   ovf_clr      : clears evt_overflow (a simultaneous new overflow wins)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN        = 3,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BTN-1:0]    btn_raw,
  output logic [N_BTN-1:0]    btn_level,
  output logic [N_BTN-1:0]    btn_press,
  output logic                evt_valid,
  output logic [EVT_ID_W-1:0] evt_id,
  input  logic                evt_ready,
  output logic                evt_overflow,
  input  logic                ovf_clr
);

  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] pending_n;
  logic [3:0]       mask4;
  logic             accept;
  logic             ovf_set;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[g]),
      .level(btn_level[g]),
      .press(btn_press[g])
    );
  end

  always_comb begin
    mask4             = '0;
    mask4[N_BTN-1:0]  = pending;
  end

  assign evt_valid = |pending;
  assign evt_id    = lowest_set(mask4);
  assign accept    = evt_valid & evt_ready;

  // A press on a bit being accepted this cycle re-arms it instead of
  // counting as lost.
  always_comb begin
    logic clr;
    pending_n = pending;
    ovf_set   = 1'b0;
    clr       = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      clr          = accept && (evt_id == EVT_ID_W'(i));
      pending_n[i] = btn_press[i] | (pending[i] & ~clr);
      if (btn_press[i] && pending[i] && !clr)
        ovf_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending <= pending_n;
      if (ovf_set)
        evt_overflow <= 1'b1;
      else if (ovf_clr)
        evt_overflow <= 1'b0;
    end
  end

endmodule
